// File: rtl/mem_responder.sv
// Word-organized data memory with a valid/ready request/response pair, programmable wait states,
// byte-enabled stores and, under MEM_RESPONDER_ERR_EN, alignment/range error reporting.
module mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h10010000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef struct packed {
    logic                 we;
    logic [NUM_LANES-1:0] be;
    logic [31:0]          addr;
    logic [31:0]          wdata;
  } req_t;

  state_e      state_q;
  logic [3:0]  cnt_q;
  req_t        req_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [AW-1:0]                idx;
  logic                         acc_err;
  logic                         commit;
  logic [NUM_LANES-1:0][7:0]    rd_word;

`ifdef MEM_RESPONDER_ERR_EN
  logic [31:0] off;
  logic [32:0] lim;
  logic        unused_off;
  assign off        = req_q.addr - ADDR_BASE;
  assign idx        = off[AW+1:2];
  assign unused_off = ^{off[31:AW+2], off[1:0]};
  assign lim        = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);
  assign acc_err    = (req_q.addr[1:0] != 2'b00) || (req_q.addr < ADDR_BASE) ||
                      ({1'b0, req_q.addr} >= lim);
`else
  // Addresses wrap modulo the array; high bits and byte offset are don't-care.
  logic unused_addr;
  assign idx         = req_q.addr[AW+1:2];
  assign unused_addr = ^{req_q.addr[31:AW+2], req_q.addr[1:0]};
  assign acc_err     = 1'b0;
`endif

  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

  // One byte array per lane so byte enables map to independent write ports.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
      if (commit && req_q.we && req_q.be[g] && !acc_err)
        mem[idx] <= req_q.wdata[8*g +: 8];
    end
    assign rd_word[g] = mem[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          req_q   <= '{we: req_we, be: req_be, addr: req_addr, wdata: req_wdata};
          cnt_q   <= 4'(WAIT_CYCLES);
          state_q <= BUSY;
        end
        BUSY: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          err_q   <= acc_err;
          rdata_q <= acc_err ? 32'hDEADBEEF : (req_q.we ? 32'h0 : rd_word);
          state_q <= RESP;
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // rst gates ready so nothing is accepted while reset is asserted.
  assign req_ready = rst && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder plus hand-written stall and reset sequences.
module tb_mem_responder;

  localparam logic [31:0] BASE = 32'h10010000;
  localparam int          WAIT = 2;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic run_txn(input vec_t v, input bit stall);
    int          edges;
    logic [31:0] hold_rd;
    logic        hold_err;
    @(negedge clk);
    rsp_ready = !stall;
    req_valid = 1'b1; req_we = v.we; req_be = v.be; req_addr = v.addr; req_wdata = v.wdata;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    // Scramble request inputs: they must only be sampled at acceptance.
    req_valid = 1'b0; req_we = ~v.we; req_be = ~v.be;
    req_addr = v.addr ^ 32'h4; req_wdata = ~v.wdata;
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    edges = 0;
    while (!rsp_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", edges, WAIT + 1);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
    if (stall) begin
      hold_rd = rsp_rdata; hold_err = rsp_err;
      repeat (5) begin
        @(posedge clk); #1;
        chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
        chk("stall_rdata", rsp_rdata, hold_rd);
        chk("stall_err", {31'b0, rsp_err}, {31'b0, hold_err});
        chk("stall_ready", {31'b0, req_ready}, 32'd0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_hs_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;

    add(1, 4'hF, 32'h10010008, 32'hCAFEF00D, 32'h0,        0);
    add(0, 4'h0, 32'h10010008, 32'h0,        32'hCAFEF00D, 0);
    add(1, 4'hF, 32'h1001000C, 32'h11223344, 32'h0,        0);
    add(1, 4'h5, 32'h1001000C, 32'hAABBCCDD, 32'h0,        0);
    add(0, 4'hF, 32'h1001000C, 32'h0,        32'h11BB33DD, 0);
    add(1, 4'h0, 32'h1001000C, 32'h12345678, 32'h0,        0);
    add(0, 4'h0, 32'h1001000C, 32'h0,        32'h11BB33DD, 0);
    add(1, 4'h8, 32'h1001000C, 32'hFFFFFFFF, 32'h0,        0);
    add(0, 4'h0, 32'h1001000C, 32'h0,        32'hFFBB33DD, 0);
    add(1, 4'hF, 32'h10010FFC, 32'hA5A50001, 32'h0,        0);
    add(0, 4'h0, 32'h10010FFC, 32'h0,        32'hA5A50001, 0);
    add(1, 4'hF, 32'h10010000, 32'h01020304, 32'h0,        0);
`ifdef MEM_RESPONDER_ERR_EN
    add(0, 4'h0, 32'h10010002, 32'h0,        32'hDEADBEEF, 1);
    add(1, 4'hF, 32'h00400000, 32'hFFFFFFFF, 32'hDEADBEEF, 1);
    add(1, 4'hF, 32'h10011000, 32'hFFFFFFFF, 32'hDEADBEEF, 1);
    add(1, 4'hF, 32'h1000FFFC, 32'hFFFFFFFF, 32'hDEADBEEF, 1);
    add(0, 4'h0, 32'h10010000, 32'h0,        32'h01020304, 0);
    add(0, 4'h0, 32'h10010FFC, 32'h0,        32'hA5A50001, 0);
`else
    // Word 1024 aliases word 0.
    add(1, 4'hF, 32'h10011000, 32'h00000077, 32'h0,        0);
    add(0, 4'h0, 32'h10010000, 32'h0,        32'h00000077, 0);
    add(0, 4'h0, 32'h10010003, 32'h0,        32'h00000077, 0);
`endif

    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rel_ready", {31'b0, req_ready}, 32'd1);

    foreach (vecs[i]) run_txn(vecs[i], 1'b0);

    // Response-side stall.
    v.we = 0; v.be = 4'h0; v.addr = 32'h10010008; v.wdata = 32'h0;
    v.exp_rdata = 32'hCAFEF00D; v.exp_err = 0;
    run_txn(v, 1'b1);

    // Reset mid-store: clear the word, then abort a store before its commit edge.
    v.we = 1; v.be = 4'hF; v.addr = 32'h10010010; v.wdata = 32'h0; v.exp_rdata = 32'h0;
    run_txn(v, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
    req_addr = 32'h10010010; req_wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_hold_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rel_ready", {31'b0, req_ready}, 32'd1);
    v.we = 0; v.be = 4'h0; v.addr = 32'h10010010; v.wdata = 32'h0; v.exp_rdata = 32'h0;
    run_txn(v, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
